// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM controller command port between
// PortCount requesters with round-robin fairness, steers read data back to
// the issuing port, and bounds each transaction with a watchdog.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for cmdReady and a pending request; grants here
// ST_ISSUE  | one-cycle cmdTrigger / reqAccept pulse for the owner
// ST_SETTLE | ignores cmdReady while the controller drops it; clears watchdog
// ST_BUSY   | waits for cmdReady or watchdog expiry
module sdram_port_arbiter #(
    parameter int PortCount     = 4,
    parameter int AddrWidth     = 23,
    parameter int DataWidth     = 16,
    parameter int TimeoutCycles = 4095
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PortCount-1:0]           reqValid,
    input  logic [PortCount*AddrWidth-1:0] reqAddr,
    input  logic [PortCount-1:0]           reqWrite,
    input  logic [PortCount*DataWidth-1:0] reqWriteData,
    output logic [PortCount-1:0]           reqAccept,
    output logic [DataWidth-1:0]           reqReadData,
    output logic [PortCount-1:0]           reqReadDataValid,
    output logic                           errTimeout,
    input  logic                           cmdReady,
    output logic                           cmdTrigger,
    output logic [AddrWidth-1:0]           cmdAddr,
    output logic                           cmdWrite,
    output logic [DataWidth-1:0]           cmdWriteData,
    input  logic [DataWidth-1:0]           cmdReadData,
    input  logic                           cmdReadDataValid
);

    localparam int IdxW = (PortCount > 1) ? $clog2(PortCount) : 1;
    localparam int WdW  = $clog2(TimeoutCycles + 1);
    localparam logic [IdxW-1:0] LastPort = IdxW'(PortCount - 1);
    localparam logic [WdW-1:0]  WdLast   = WdW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETTLE,
        ST_BUSY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IdxW-1:0]   owner;
    logic [IdxW-1:0]   last_grant;
    logic [IdxW-1:0]   winner;
    logic              found;
    logic              owner_is_read;
    logic              grant;
    logic              wd_clear;
    logic              wd_inc;
    logic              wd_fire;
    logic [WdW-1:0]    wd_cnt;

    // Round-robin search: first pending port after last_grant, wrapping.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        for (int k = 1; k <= PortCount; k++) begin
            if (!found && reqValid[(int'(last_grant) + k) % PortCount]) begin
                winner = IdxW'((int'(last_grant) + k) % PortCount);
                found  = 1'b1;
            end
        end
    end

    // Next-state decode with grant and watchdog controls.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        wd_clear  = 1'b0;
        wd_inc    = 1'b0;
        wd_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmdReady && (|reqValid)) begin
                    grant     = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                wd_clear  = 1'b1;
                state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (cmdReady) begin
                    state_nxt = ST_IDLE;
                end else if (wd_cnt == WdLast) begin
                    wd_fire   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Latch the winner and its command fields at grant; they hold until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner         <= '0;
            last_grant    <= LastPort;
            owner_is_read <= 1'b0;
            cmdAddr       <= '0;
            cmdWrite      <= 1'b0;
            cmdWriteData  <= '0;
        end else if (grant) begin
            owner         <= winner;
            last_grant    <= winner;
            owner_is_read <= ~reqWrite[winner];
            cmdAddr       <= reqAddr[int'(winner)*AddrWidth +: AddrWidth];
            cmdWrite      <= reqWrite[winner];
            cmdWriteData  <= reqWriteData[int'(winner)*DataWidth +: DataWidth];
        end
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt     <= '0;
            errTimeout <= 1'b0;
        end else begin
            if (wd_clear)    wd_cnt <= '0;
            else if (wd_inc) wd_cnt <= wd_cnt + 1'b1;
            if (wd_fire) errTimeout <= 1'b1;
        end
    end

    assign cmdTrigger  = (state == ST_ISSUE);
    assign reqReadData = cmdReadData;

    // One-hot accept pulse and zero-latency read-data steering to the owner.
    always_comb begin
        reqAccept        = '0;
        reqReadDataValid = '0;
        if (state == ST_ISSUE) reqAccept[owner] = 1'b1;
        for (int i = 0; i < PortCount; i++) begin
            reqReadDataValid[i] = cmdReadDataValid & owner_is_read & (owner == IdxW'(i));
        end
    end

endmodule
